bus_rr_arbiter: RTL and testbench
=================================

Name: bus_rr_arbiter

Overview:
Round-robin arbiter that shares one 32-bit datapath bus among NUM_REQ requesters.
- Drives the select input of a 32-bit N:1 mux and the bus output itself.
- Used between the CPU, DMA and debug masters ahead of the memory data port.
- Grants are held until the owner releases. Ownership changes only at release or revocation.

Parameters:
NUM_REQ, 4, number of requesters; power of two, 2..32
SEL_W, 2, select width; equals log2(NUM_REQ)
DATA_W, 32, bus data width
HOLD_MAX, 16, maximum grant length in cycles (used only with ARB_TIMEOUT_EN)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
REQ  input  NUM_REQ  per-requester request level; held high until granted and done
REL  input  NUM_REQ  per-requester release pulse; only the owner's bit is honoured
DIN  input  NUM_REQ*DATA_W  flattened requester data; requester i occupies bits [i*DATA_W +: DATA_W]
GNT  output  NUM_REQ  one-hot grant, registered
SEL  output  SEL_W  binary index of the owner, registered
BUS  output  DATA_W  DIN slice selected by SEL, combinational from registered SEL and DIN
BUSY  output  1  high while any grant is active
REVOKED  output  1  one-cycle pulse when a grant is forcibly removed

Behaviour:
- Reset: the clock is CLK; reset RST is asynchronous, active-low.
  - While RST=0: GNT=0, SEL=0, BUSY=0, REVOKED=0, priority pointer PTR=0, state=IDLE, hold counter=0.
  - BUS then shows DIN slice 0.
- States: IDLE, OWN.
- IDLE, when any REQ bit is set:
  - Choose the first set REQ bit searching upward from PTR, wrapping modulo NUM_REQ.
  - Next edge: GNT sets that one-hot bit, SEL holds its index, BUSY=1, state goes to OWN.
  - Latency from REQ rising to GNT is 1 cycle.
- IDLE with no requests: outputs are unchanged at zero. PTR is unchanged.
- OWN, when REL[SEL]=1 or REQ[SEL]=0:
  - Next edge: PTR=(SEL+1) mod NUM_REQ; GNT and BUSY clear; state goes to IDLE.
  - The bus is always idle for at least one cycle between owners. There are no back-to-back grants.
- OWN, other requests and other REL bits: ignored. GNT, SEL and BUS are stable.
- Simultaneous REL and a new request by the same requester: the release wins. That requester is re-granted only after the round-robin search with the advanced PTR.
- Fairness: with all REQ held high, the grant order is 0,1,2,3,0,...
  - Worst-case wait is (NUM_REQ-1) ownership periods plus 2·NUM_REQ idle and grant cycles.
- Wrap-around: PTR increments modulo NUM_REQ, so PTR=NUM_REQ-1 followed by a release gives PTR=0.
- Mux: BUS equals DIN[SEL*DATA_W +: DATA_W] at all times, including when BUSY=0. Consumers qualify BUS with BUSY.
- Reset asserted mid-grant: GNT drops immediately (asynchronously). No REVOKED pulse is produced.
- Invariants:
  - GNT is zero or one-hot.
  - GNT[SEL]=BUSY.
  - REVOKED is never high together with GNT in the same cycle it asserts.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on grant and increments each cycle in OWN.
  - When the counter reaches HOLD_MAX-1 without a release, the next edge forces the same transition as a release, and REVOKED pulses high for 1 cycle.
  - A release in the same cycle as the timeout counts as a normal release; REVOKED stays 0.
- Undefined: the counter logic is absent and REVOKED is tied to 0. A grant lasts until release with no bound.

Test Plan:
1. Reset: hold RST=0 with REQ=4'b1111 -> GNT=0, SEL=0, BUSY=0. Release reset -> one cycle later GNT=4'b0001, BUS=DIN slice 0.
2. Rotation: REQ=4'b1111 held, each owner pulses REL 3 cycles after its grant -> grant sequence 0001, 0010, 0100, 1000, 0001, with one idle cycle (GNT=0) between each.
3. Sparse and wrap: PTR=3 and REQ=4'b0101 -> GNT=0001 (wraps past 3). After release -> GNT=0100.
4. Stability: requester 2 owns the bus and DIN slice 2=32'hDEADBEEF; REQ[0] rises and REL[1] pulses -> GNT stays 0100 and BUS stays 32'hDEADBEEF until REL[2].
5. Mid-grant reset: requester 1 owns the bus; RST drops between clock edges -> GNT=0 and SEL=0 immediately; PTR=0 after reset is released.
6. (ARB_TIMEOUT_EN, HOLD_MAX=16) Requester 3 is granted and never releases -> 16 cycles later GNT=0 with REVOKED=1 for one cycle. With REQ=4'b1001 the next grant is 0001.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for a shared data bus: holds the grant until the owner releases and muxes the owner's data onto BUS.
// Optional ARB_TIMEOUT_EN adds a hold counter that revokes a grant after HOLD_MAX cycles.
module bus_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SEL_W    = 2,
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ-1:0]        REL,
  input  logic [NUM_REQ*DATA_W-1:0] DIN,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [SEL_W-1:0]          SEL,
  output logic [DATA_W-1:0]         BUS,
  output logic                      BUSY,
  output logic                      REVOKED
);

  if (NUM_REQ != (1 << SEL_W) || NUM_REQ < 2 || HOLD_MAX < 1) begin : g_param_chk
    $error("bus_rr_arbiter: NUM_REQ must equal 2**SEL_W (>=2) and HOLD_MAX must be >= 1");
  end

  typedef enum logic {IDLE, OWN} state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 busy_q, busy_d;
  logic                 revoke_d;
  logic                 timeout;
  logic                 owner_rel;
  logic                 pick_found;
  logic [SEL_W-1:0]     pick_idx;
  logic [SEL_W-1:0]     cand;

  // Search upward from ptr_q; the SEL_W-bit add wraps modulo NUM_REQ for free.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr_q + SEL_W'(i);
      if (!pick_found && REQ[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_rel = REL[sel_q] | ~REQ[sel_q];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    busy_d   = busy_q;
    revoke_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWN;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          sel_d   = pick_idx;
          busy_d  = 1'b1;
        end
      end
      OWN: begin
        if (owner_rel || timeout) begin
          state_d  = IDLE;
          ptr_d    = sel_q + SEL_W'(1);
          gnt_d    = '0;
          busy_d   = 1'b0;
          revoke_d = timeout & ~owner_rel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              revoked_q;

  // Counter sits at zero in IDLE, so it is already cleared on the grant edge.
  assign hold_d  = (state_q == OWN) ? hold_q + HOLD_W'(1) : '0;
  assign timeout = (state_q == OWN) && (hold_q == HOLD_W'(HOLD_MAX - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_q    <= '0;
      revoked_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      revoked_q <= revoke_d;
    end
  end

  assign REVOKED = revoked_q;
`else
  assign timeout = 1'b0;
  assign REVOKED = 1'b0;
`endif

  assign GNT  = gnt_q;
  assign SEL  = sel_q;
  assign BUSY = busy_q;
  assign BUS  = DIN[int'(sel_q)*DATA_W +: DATA_W];

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: table of per-cycle vectors plus hand sequences for reset and timeout.
module tb_bus_rr_arbiter;

  logic         CLK = 1'b0;
  logic         RST;
  logic [3:0]   REQ;
  logic [3:0]   REL;
  logic [127:0] DIN;
  logic [3:0]   GNT;
  logic [1:0]   SEL;
  logic [31:0]  BUS;
  logic         BUSY;
  logic         REVOKED;

  logic [31:0] slice_v [4];
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t vecs [36];

  bus_rr_arbiter #(.NUM_REQ(4), .SEL_W(2), .DATA_W(32), .HOLD_MAX(16)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REL(REL), .DIN(DIN),
    .GNT(GNT), .SEL(SEL), .BUS(BUS), .BUSY(BUSY), .REVOKED(REVOKED)
  );

  always #5 CLK = ~CLK;

  assign DIN = {slice_v[3], slice_v[2], slice_v[1], slice_v[0]};

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                       input logic eb, input logic er);
    cmp({name, ".gnt"}, 32'(GNT), 32'(eg));
    cmp({name, ".sel"}, 32'(SEL), 32'(es));
    cmp({name, ".busy"}, 32'(BUSY), 32'(eb));
    cmp({name, ".bus"}, BUS, slice_v[es]);
    cmp({name, ".revoked"}, 32'(REVOKED), 32'(er));
  endtask

  initial begin
    slice_v[0] = 32'h1111_0000;
    slice_v[1] = 32'h2222_0001;
    slice_v[2] = 32'hDEAD_BEEF;
    slice_v[3] = 32'h4444_0003;

    // rotation with REQ=1111, REL 3 cycles after each grant
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};
    vecs[3]  = '{4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1};
    vecs[7]  = '{4'b1111, 4'b0010, 4'b0000, 2'd1, 1'b0};
    vecs[8]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1};
    vecs[9]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1};
    vecs[10] = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1};
    vecs[11] = '{4'b1111, 4'b0100, 4'b0000, 2'd2, 1'b0};
    vecs[12] = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1};
    vecs[13] = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1};
    vecs[14] = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1};
    vecs[15] = '{4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0};
    vecs[16] = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};
    vecs[17] = '{4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0};
    // steer PTR to 3, then sparse request wraps to 0
    vecs[18] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1};
    vecs[19] = '{4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0};
    vecs[20] = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1};
    vecs[21] = '{4'b0101, 4'b0001, 4'b0000, 2'd0, 1'b0};
    vecs[22] = '{4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1};
    // owner dropping REQ acts as a release; idle holds SEL
    vecs[23] = '{4'b0001, 4'b0000, 4'b0000, 2'd2, 1'b0};
    vecs[24] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};
    vecs[25] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};
    // stability: non-owner REQ/REL ignored while 2 owns DEADBEEF
    vecs[26] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1};
    vecs[27] = '{4'b0101, 4'b0010, 4'b0100, 2'd2, 1'b1};
    vecs[28] = '{4'b0101, 4'b0001, 4'b0100, 2'd2, 1'b1};
    vecs[29] = '{4'b1101, 4'b0000, 4'b0100, 2'd2, 1'b1};
    vecs[30] = '{4'b0101, 4'b0100, 4'b0000, 2'd2, 1'b0};
    vecs[31] = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1};
    // release plus re-request by same requester: advanced PTR picks 1
    vecs[32] = '{4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0};
    vecs[33] = '{4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1};
    vecs[34] = '{4'b0011, 4'b0010, 4'b0000, 2'd1, 1'b0};
    vecs[35] = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0};

    RST = 1'b0;
    REQ = 4'b1111;
    REL = 4'b0000;
    #12;
    check("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b1;

    for (int i = 0; i < 36; i++) begin
      REQ = vecs[i].req;
      REL = vecs[i].rel;
      step();
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy, 1'b0);
      if (i == 29) cmp("stable_bus", BUS, 32'hDEAD_BEEF);
    end

    // mid-grant asynchronous reset (PTR is 2 here)
    REQ = 4'b0010;
    REL = 4'b0000;
    step();
    check("pre_rst_own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    #3;
    RST = 1'b0;
    #1;
    check("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    REQ = 4'b1111;
    step();
    check("post_rst_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    REL = 4'b0001;
    step();
    check("to_rel0", 4'b0000, 2'd0, 1'b0, 1'b0);
    REL = 4'b0000;
    REQ = 4'b1000;
    step();
    check("to_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    for (int k = 1; k < 16; k++) begin
      step();
      check($sformatf("to_hold%0d", k), 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    step();
    check("to_revoke", 4'b0000, 2'd3, 1'b0, 1'b1);
    REQ = 4'b1001;
    step();
    check("to_next", 4'b0001, 2'd0, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
